// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and default widths
// for the sprite compositor and its timing core.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int DEF_COORD_W = 12;
    localparam int DEF_COLOR_W = 12;

endpackage

// File: rtl/vga_timing_core.sv
// Pixel-tick divider, h/v raster counters, raw syncs and the
// once-per-frame latch strobe at the start of vertical blanking.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int COORD_W = DEF_COORD_W,
    parameter int H_VIS   = H_ACTIVE,
    parameter int H_FRONT = H_FP,
    parameter int H_PULSE = H_SYNC,
    parameter int H_BACK  = H_BP,
    parameter int V_VIS   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_PULSE = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic               clk,
    input  logic               reset,
    output logic               tick,
    output logic [COORD_W-1:0] h_cnt,
    output logic [COORD_W-1:0] v_cnt,
    output logic               active,
    output logic               h_sync,
    output logic               v_sync,
    output logic               latch
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int H_TOT = H_VIS + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOT = V_VIS + V_FRONT + V_PULSE + V_BACK;
    localparam int HS_LO = H_VIS + H_FRONT;
    localparam int VS_LO = V_VIS + V_FRONT;

    logic [DIV_W-1:0] div;

    // CLK_DIV is a power of two, so the divider simply wraps
    always_ff @(posedge clk) begin
        if (!reset) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= div + 1'b1;
            if (tick) begin
                if (h_cnt == COORD_W'(H_TOT - 1)) begin
                    h_cnt <= '0;
                    if (v_cnt == COORD_W'(V_TOT - 1)) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign tick   = (div == DIV_W'(CLK_DIV - 1));
    assign active = (h_cnt < COORD_W'(H_VIS))
                 && (v_cnt < COORD_W'(V_VIS));
    assign h_sync = !((h_cnt >= COORD_W'(HS_LO))
                   && (h_cnt < COORD_W'(HS_LO + H_PULSE)));
    assign v_sync = !((v_cnt >= COORD_W'(VS_LO))
                   && (v_cnt < COORD_W'(VS_LO + V_PULSE)));
    assign latch  = tick && (h_cnt == '0)
                 && (v_cnt == COORD_W'(V_VIS));

endmodule

// File: rtl/vga_sprite_compositor.sv
// Composites NUM_SPRITES frame-latched rectangles over a background
// colour with a 2-tick output pipeline and sprite-0 collision flags.
module vga_sprite_compositor
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int CLK_DIV     = 4,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int H_VIS       = H_ACTIVE,
    parameter int H_FRONT     = H_FP,
    parameter int H_PULSE     = H_SYNC,
    parameter int H_BACK      = H_BP,
    parameter int V_VIS       = V_ACTIVE,
    parameter int V_FRONT     = V_FP,
    parameter int V_PULSE     = V_SYNC,
    parameter int V_BACK      = V_BP
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_w,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_h,
    input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    output logic [COORD_W-1:0]             pixel_x,
    output logic [COORD_W-1:0]             pixel_y,
    input  logic [COLOR_W-1:0]             bg_color,
    output logic                           hSync,
    output logic                           vSync,
    output logic [3:0]                     VGA_R,
    output logic [3:0]                     VGA_G,
    output logic [3:0]                     VGA_B,
    output logic                           frame_done,
    output logic [NUM_SPRITES-2:0]         collision
);

    typedef struct packed {
        logic [NUM_SPRITES-1:0] hit;
        logic [COLOR_W-1:0]     bg;
        logic                   active;
        logic                   hs;
        logic                   vs;
    } s1_t;

    logic               tick;
    logic               active;
    logic               hs_raw;
    logic               vs_raw;
    logic               latch;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;

    vga_timing_core #(
        .CLK_DIV (CLK_DIV),
        .COORD_W (COORD_W),
        .H_VIS   (H_VIS),
        .H_FRONT (H_FRONT),
        .H_PULSE (H_PULSE),
        .H_BACK  (H_BACK),
        .V_VIS   (V_VIS),
        .V_FRONT (V_FRONT),
        .V_PULSE (V_PULSE),
        .V_BACK  (V_BACK)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .h_sync (hs_raw),
        .v_sync (vs_raw),
        .latch  (latch)
    );

    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;
    assign frame_done = latch;

    logic [COORD_W-1:0]     sh_x [NUM_SPRITES];
    logic [COORD_W-1:0]     sh_y [NUM_SPRITES];
    logic [COORD_W-1:0]     sh_w [NUM_SPRITES];
    logic [COORD_W-1:0]     sh_h [NUM_SPRITES];
    logic [COLOR_W-1:0]     sh_c [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
                sh_w[i] <= '0;
                sh_h[i] <= '0;
                sh_c[i] <= '0;
            end
            sh_en <= '0;
        end else if (latch) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i] <= sprite_x[i*COORD_W +: COORD_W];
                sh_y[i] <= sprite_y[i*COORD_W +: COORD_W];
                sh_w[i] <= sprite_w[i*COORD_W +: COORD_W];
                sh_h[i] <= sprite_h[i*COORD_W +: COORD_W];
                sh_c[i] <= sprite_color[i*COLOR_W +: COLOR_W];
            end
            sh_en <= sprite_en;
        end
    end

    logic [NUM_SPRITES-1:0] hit;
    logic [COORD_W:0]       px;
    logic [COORD_W:0]       py;

    assign px = {1'b0, h_cnt};
    assign py = {1'b0, v_cnt};

    // one extra bit keeps x+w-1 and y+1 from wrapping
    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        logic [COORD_W:0] x_lo;
        logic [COORD_W:0] x_hi;
        logic [COORD_W:0] y_lo;
        logic [COORD_W:0] y_hi;
        logic [COORD_W:0] y_p1;
        logic [COORD_W:0] h_ext;

        assign x_lo  = {1'b0, sh_x[i]};
        assign x_hi  = x_lo + {1'b0, sh_w[i]} - 1'b1;
        assign y_hi  = {1'b0, sh_y[i]};
        assign y_p1  = y_hi + 1'b1;
        assign h_ext = {1'b0, sh_h[i]};
        assign y_lo  = (h_ext > y_p1) ? '0 : y_p1 - h_ext;

        assign hit[i] = sh_en[i] && (|sh_w[i]) && (|sh_h[i])
                     && (px >= x_lo) && (px <= x_hi)
                     && (py >= y_lo) && (py <= y_hi);
    end

    s1_t                s1;
    logic [COLOR_W-1:0] pick;
    logic [COLOR_W-1:0] s2_col;
    logic               s2_hs;
    logic               s2_vs;

    always_comb begin
        pick = s1.bg;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (s1.hit[i]) begin
                pick = sh_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1     <= '{hit: '0, bg: '0, active: 1'b0,
                        hs: 1'b1, vs: 1'b1};
            s2_col <= '0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
        end else if (tick) begin
            s1     <= '{hit: hit, bg: bg_color, active: active,
                        hs: hs_raw, vs: vs_raw};
            s2_col <= s1.active ? pick : '0;
            s2_hs  <= s1.hs;
            s2_vs  <= s1.vs;
        end
    end

    assign hSync = s2_hs;
    assign vSync = s2_vs;
    assign VGA_R = s2_col[COLOR_W-1 -: 4];
    assign VGA_G = s2_col[COLOR_W-5 -: 4];
    assign VGA_B = s2_col[COLOR_W-9 -: 4];

    logic [NUM_SPRITES-2:0] term;
    logic [NUM_SPRITES-2:0] acc;

    for (genvar i = 1; i < NUM_SPRITES; i++) begin : g_term
        assign term[i-1] = s1.active & s1.hit[0] & s1.hit[i];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= '0;
            collision <= '0;
        end else if (latch) begin
            collision <= acc | term;
            acc       <= '0;
        end else if (tick) begin
            acc <= acc | term;
        end
    end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench: a full-size instance for reset/hSync timing and a
// shrunken-raster instance for compositing, latching and collisions.
`timescale 1ns/1ps
module tb_vga_sprite_compositor;

    localparam int N   = 4;
    localparam int CW  = 12;
    localparam int KW  = 12;
    localparam int DIV = 2;
    localparam int HV  = 16;
    localparam int HF  = 2;
    localparam int HP  = 4;
    localparam int HB  = 2;
    localparam int VV  = 8;
    localparam int VF  = 2;
    localparam int VP  = 2;
    localparam int VB  = 2;
    localparam int FRAME_CLKS = DIV * (HV + HF + HP + HB) * (VV + VF + VP + VB);
    localparam int LIMIT = 2 * FRAME_CLKS + 16;

    logic clk = 1'b0;
    logic rst_sm;
    logic rst_big;

    logic [N*CW-1:0] sx, sy, sw, sh;
    logic [N*KW-1:0] sc;
    logic [N-1:0]    sen;
    logic [CW-1:0]   px, py;
    logic [KW-1:0]   bg;
    logic            hs, vs, fd;
    logic [3:0]      r, g, b;
    logic [N-2:0]    coll;

    logic [CW-1:0]   px_b, py_b;
    logic            hs_b, vs_b, fd_b;
    logic [3:0]      r_b, g_b, b_b;
    logic [N-2:0]    coll_b;

    int total = 0;
    int bad = 0;
    int n;

    always #5 clk = ~clk;

    assign bg = {4'h0, px[3:0], py[3:0]};

    vga_sprite_compositor #(
        .NUM_SPRITES (N),
        .CLK_DIV     (DIV),
        .COORD_W     (CW),
        .COLOR_W     (KW),
        .H_VIS (HV), .H_FRONT (HF), .H_PULSE (HP), .H_BACK (HB),
        .V_VIS (VV), .V_FRONT (VF), .V_PULSE (VP), .V_BACK (VB)
    ) dut (
        .clk          (clk),
        .reset        (rst_sm),
        .sprite_x     (sx),
        .sprite_y     (sy),
        .sprite_w     (sw),
        .sprite_h     (sh),
        .sprite_color (sc),
        .sprite_en    (sen),
        .pixel_x      (px),
        .pixel_y      (py),
        .bg_color     (bg),
        .hSync        (hs),
        .vSync        (vs),
        .VGA_R        (r),
        .VGA_G        (g),
        .VGA_B        (b),
        .frame_done   (fd),
        .collision    (coll)
    );

    vga_sprite_compositor #(
        .NUM_SPRITES (N)
    ) dut_big (
        .clk          (clk),
        .reset        (rst_big),
        .sprite_x     ('0),
        .sprite_y     ('0),
        .sprite_w     ('0),
        .sprite_h     ('0),
        .sprite_color ('0),
        .sprite_en    ('0),
        .pixel_x      (px_b),
        .pixel_y      (py_b),
        .bg_color     (12'h0F0),
        .hSync        (hs_b),
        .vSync        (vs_b),
        .VGA_R        (r_b),
        .VGA_G        (g_b),
        .VGA_B        (b_b),
        .frame_done   (fd_b),
        .collision    (coll_b)
    );

    function automatic logic [11:0] bgf(input int x, input int y);
        return {4'h0, 4'(x), 4'(y)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sprite(input int i, input int x, input int y,
                              input int w, input int h,
                              input logic [11:0] c, input logic en);
        sx[i*CW +: CW] = CW'(x);
        sy[i*CW +: CW] = CW'(y);
        sw[i*CW +: CW] = CW'(w);
        sh[i*CW +: CW] = CW'(h);
        sc[i*KW +: KW] = c;
        sen[i] = en;
    endtask

    // pixel (x,y) is on the outputs while the counters show (x+2,y)
    task automatic check_px(input string tag, input int x, input int y,
                            input logic [11:0] exp);
        int k = 0;
        while (!(px == CW'(x + 2) && py == CW'(y)) && k < LIMIT) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " reach"}, 32'(k < LIMIT), 32'd1);
        chk(tag, 32'({r, g, b}), 32'(exp));
    endtask

    task automatic wait_fd();
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!fd && k < LIMIT);
        chk("frame_done seen", 32'(fd), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_row(input int y);
        int k = 0;
        while (py != CW'(y) && k < LIMIT) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("row reach", 32'(k < LIMIT), 32'd1);
    endtask

    initial begin
        rst_sm  = 1'b0;
        rst_big = 1'b0;
        sx = '0; sy = '0; sw = '0; sh = '0; sc = '0; sen = '0;
        set_sprite(0, 3, 5, 4, 3, 12'hC10, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst hsync", 32'(hs), 32'd1);
        chk("rst vsync", 32'(vs), 32'd1);
        chk("rst rgb", 32'({r, g, b}), 32'd0);
        chk("rst collision", 32'(coll), 32'd0);
        chk("rst frame_done", 32'(fd), 32'd0);
        chk("rst pixel_x", 32'(px), 32'd0);
        chk("rst big hsync", 32'(hs_b), 32'd1);
        chk("rst big vsync", 32'(vs_b), 32'd1);
        chk("rst big rgb", 32'({r_b, g_b, b_b}), 32'd0);

        rst_big = 1'b1;
        n = 0;
        while (hs_b !== 1'b0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("big first hsync fall", n, 32'd2632);

        rst_sm = 1'b1;
        n = 0;
        while (hs !== 1'b0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first hsync fall", n, 32'(DIV * (HV + HF + 2)));

        check_px("no sprite before first latch", 3, 3, bgf(3, 3));

        n = 0;
        while (vs !== 1'b0 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("vsync reach", 32'(n < LIMIT), 32'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (vs !== 1'b1 && n < LIMIT);
        while (vs !== 1'b0 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("vsync period", n, 32'(FRAME_CLKS));

        wait_fd();
        check_px("above sprite", 3, 2, bgf(3, 2));
        check_px("left of sprite", 2, 3, bgf(2, 3));
        check_px("sprite top-left", 3, 3, 12'hC10);
        chk("hsync high active", 32'(hs), 32'd1);
        check_px("right of sprite", 7, 3, bgf(7, 3));
        check_px("h blanking", 20, 3, 12'h000);
        chk("hsync low in pulse", 32'(hs), 32'd0);
        check_px("sprite bottom-right", 6, 5, 12'hC10);
        check_px("below sprite", 3, 6, bgf(3, 6));
        check_px("v blanking", 3, 10, 12'h000);
        chk("vsync low in pulse", 32'(vs), 32'd0);

        set_sprite(1, 5, 5, 4, 2, 12'hC13, 1'b1);
        wait_fd();
        chk("no overlap yet", 32'(coll), 32'd0);
        check_px("s0 only", 6, 3, 12'hC10);
        check_px("s0 left of s1", 4, 4, 12'hC10);
        check_px("overlap s1 wins", 5, 4, 12'hC13);
        check_px("s1 right edge", 8, 4, 12'hC13);
        check_px("past s1", 9, 4, bgf(9, 4));
        check_px("overlap row 5", 6, 5, 12'hC13);
        wait_fd();
        chk("collision set", 32'(coll), 32'd1);

        set_sprite(1, 10, 5, 4, 2, 12'hC13, 1'b1);
        wait_fd();
        chk("collision held", 32'(coll), 32'd1);
        wait_fd();
        chk("collision cleared", 32'(coll), 32'd0);

        set_sprite(1, 15, 5, 50, 2, 12'hC13, 1'b1);
        set_sprite(0, 18, 5, 4, 3, 12'hC10, 1'b1);
        wait_fd();
        chk("separate frame", 32'(coll), 32'd0);
        check_px("left of edge sprite", 14, 4, bgf(14, 4));
        check_px("edge sprite last col", 15, 4, 12'hC13);
        check_px("clipped region", 16, 4, 12'h000);
        wait_fd();
        chk("offscreen overlap ignored", 32'(coll), 32'd0);

        set_sprite(0, 3, 5, 4, 3, 12'hC10, 1'b1);
        set_sprite(1, 10, 5, 4, 2, 12'hC13, 1'b0);
        wait_fd();
        wait_fd();
        wait_row(4);
        set_sprite(0, 8, 5, 4, 3, 12'hC10, 1'b1);
        check_px("mid-frame old pos", 3, 5, 12'hC10);
        check_px("mid-frame new pos empty", 8, 5, bgf(8, 5));
        wait_fd();
        check_px("next frame old pos empty", 3, 5, bgf(3, 5));
        check_px("next frame new pos", 8, 5, 12'hC10);

        set_sprite(2, 10, 1, 2, 6, 12'hABC, 1'b1);
        set_sprite(3, 8, 5, 1, 1, 12'h777, 1'b1);
        wait_fd();
        chk("sprite0 alone", 32'(coll), 32'd0);
        check_px("clamped top row", 10, 0, 12'hABC);
        check_px("clamped bottom row", 10, 1, 12'hABC);
        check_px("below clamped", 10, 2, bgf(10, 2));
        check_px("s3 over s0", 8, 5, 12'h777);
        check_px("s0 beside s3", 9, 5, 12'hC10);
        wait_fd();
        chk("collision s3", 32'(coll), 32'b100);

        check_px("pre-reset pixel", 9, 5, 12'hC10);
        rst_sm = 1'b0;
        @(posedge clk);
        #1;
        chk("mid rst hsync", 32'(hs), 32'd1);
        chk("mid rst vsync", 32'(vs), 32'd1);
        chk("mid rst rgb", 32'({r, g, b}), 32'd0);
        chk("mid rst collision", 32'(coll), 32'd0);
        chk("mid rst frame_done", 32'(fd), 32'd0);
        chk("mid rst pixel_x", 32'(px), 32'd0);
        chk("mid rst pixel_y", 32'(py), 32'd0);
        rst_sm = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("restart pixel_x", 32'(px), 32'd1);
        chk("restart pixel_y", 32'(py), 32'd0);
        check_px("post-reset no sprites", 8, 5, bgf(8, 5));
        wait_fd();
        check_px("post-reset relatch", 8, 5, 12'h777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
